// File: rtl/lsu_subword_ctrl_if.sv
// Request/response and data-memory bus of the load/store unit.
// master: pipeline + memory side; slave: lsu_subword_ctrl.
interface lsu_subword_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  logic [31:0] mem_rd_add;
  logic        mem_read;
  logic [31:0] mem_data;
  logic [31:0] mem_wr_add;
  logic [31:0] mem_wr_data;
  logic        mem_write;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_err, resp_rdata,
    input  mem_rd_add, mem_read, mem_wr_add, mem_wr_data, mem_write,
    output mem_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_err, resp_rdata,
    output mem_rd_add, mem_read, mem_wr_add, mem_wr_data, mem_write,
    input  mem_data
  );
endinterface

// File: rtl/lsu_subword_ctrl.sv
// Load/store unit: turns byte/half/word loads and stores into word-wide
// memory transactions (read-modify-write for sub-word stores), extracts and
// extends load lanes, and flags misaligned / illegal-size accesses.
// Optional macro LSU_BOUNDS_CHECK_EN: accesses with waddr + 3 >= MEM_BYTES
// take the error path.
module lsu_subword_ctrl #(
  parameter int unsigned MEM_BYTES = 128
) (
  input logic               clk,
  input logic               rst,
  lsu_subword_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ERR, RD, CAP, WR, DONE} state_t;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t state_q, state_d;

  // Captured request fields
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;

  // Registered outputs
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_rd_add_q, mem_rd_add_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_wr_add_q, mem_wr_add_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        mem_write_q, mem_write_d;

  // Accept-time decode
  logic [31:0] req_waddr;
  logic        misalign;
  logic        oob;
  logic        req_err;

  assign req_waddr = {bus.req_addr[31:2], 2'b00};
  assign misalign  = (bus.req_size == 2'b11) ||
                     ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign oob       = BOUNDS_EN &&
                     (({1'b0, req_waddr} + 33'd3) >= 33'(MEM_BYTES));
  assign req_err   = misalign || oob;

  // Lane datapath: shifting the read word right by 8*addr[1:0] puts the
  // addressed byte or half at bit 0 (word accesses are aligned, so shift 0).
  logic [4:0]  lane_shift;
  logic [31:0] lane_word;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] merged;

  assign lane_shift = {lane_q, 3'b000};
  assign lane_word  = bus.mem_data >> lane_shift;
  assign lane_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
  assign lane_wdata = ((size_q == 2'b00) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q}) << lane_shift;
  assign merged     = (bus.mem_data & ~lane_mask) | lane_wdata;

  // Extend the extracted load lane
  always_comb begin
    load_ext = lane_word;
    case (size_q)
      2'b00:   load_ext = sgn_q ? {{24{lane_word[7]}}, lane_word[7:0]}
                                : {24'h0, lane_word[7:0]};
      2'b01:   load_ext = sgn_q ? {{16{lane_word[15]}}, lane_word[15:0]}
                                : {16'h0, lane_word[15:0]};
      default: load_ext = lane_word;
    endcase
  end

  // Next state and next registered outputs; each output is set on the
  // transition into the state in which it must be visible.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    size_d        = size_q;
    sgn_d         = sgn_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_rd_add_d  = mem_rd_add_q;
    mem_wr_add_d  = mem_wr_add_q;
    mem_wr_data_d = mem_wr_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          lane_d  = bus.req_addr[1:0];
          wdata_d = bus.req_wdata[15:0];
          if (req_err) begin
            state_d      = ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!bus.req_write || (bus.req_size != 2'b10)) begin
            state_d      = RD;
            mem_read_d   = 1'b1;
            mem_rd_add_d = req_waddr;
          end else begin
            state_d       = WR;
            mem_write_d   = 1'b1;
            mem_wr_add_d  = req_waddr;
            mem_wr_data_d = bus.req_wdata;
          end
        end
      end
      ERR:  state_d = IDLE;
      RD:   state_d = CAP;
      CAP: begin
        if (wr_q) begin
          state_d       = WR;
          mem_write_d   = 1'b1;
          mem_wr_add_d  = mem_rd_add_q;
          mem_wr_data_d = merged;
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end
      end
      WR: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State, captured request and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      size_q        <= '0;
      sgn_q         <= 1'b0;
      lane_q        <= '0;
      wdata_q       <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_rd_add_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_wr_add_q  <= '0;
      mem_wr_data_q <= '0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      size_q        <= size_d;
      sgn_q         <= sgn_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_rd_add_q  <= mem_rd_add_d;
      mem_read_q    <= mem_read_d;
      mem_wr_add_q  <= mem_wr_add_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_write_q   <= mem_write_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_rd_add  = mem_rd_add_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_wr_add  = mem_wr_add_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_write   = mem_write_q;

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
- Load/store unit between the MEM-stage pipeline and the byte-addressable data memory.
- Converts lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-wide memory transactions. The memory always writes 4 bytes, so sb/sh use read-modify-write.
- Extracts the addressed lane on loads and sign- or zero-extends it.
- Flags misaligned accesses.

Parameters:
- MEM_BYTES, 128: data memory size in bytes; used only by the optional bounds check.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as an error.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size, or (optionally) out of range.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_rd_add  out  32  word-aligned read address.
- mem_read  out  1  memory read enable.
- mem_data  in  32  memory read data, little-endian.
- mem_wr_add  out  32  word-aligned write address.
- mem_wr_data  out  32  full write word.
- mem_write  out  1  memory write enable, sampled by the memory on posedge clk.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state = IDLE.
- Reset mid-operation: the pending request is dropped with no resp_valid; mem_read and mem_write are 0 from the next cycle.
- All outputs are registered. On accept (req_valid & req_ready), req_* is captured; req_ready = 1 only in IDLE.
- Aligned word address: waddr = {addr[31:2], 2'b00}.
- Byte lane: addr[1:0] selects bits [8*lane+7 : 8*lane].
- Half lane: addr[1] selects bits [16*addr[1]+15 : 16*addr[1]].
- Error check at accept: half with addr[0] = 1, word with addr[1:0] != 0, or size 11. Error path:
  - state goes to ERR for 1 cycle with resp_valid = 1, resp_err = 1, resp_rdata = 0;
  - mem_read and mem_write never assert;
  - latency is 1 cycle from the accept cycle.
- FSM states: IDLE, ERR, RD, CAP, WR, DONE.
- Load: IDLE → RD (mem_read = 1, mem_rd_add = waddr) → CAP (sample mem_data, extract, extend) → DONE (resp_valid = 1, resp_rdata valid) → IDLE.
  - Latency 3 cycles from accept to resp_valid.
  - mem_rd_add is held stable through CAP.
- Word store: IDLE → WR (mem_write = 1, mem_wr_add = waddr, mem_wr_data = wdata) → DONE → IDLE.
  - Latency 2 cycles.
- Sub-word store: IDLE → RD → CAP (merge wdata[7:0] or wdata[15:0] into the selected lane of mem_data; other lanes unchanged) → WR → DONE.
  - Latency 4 cycles.
- mem_read and mem_write are never high in the same cycle. Each is high exactly one cycle per access.
- DONE returns to IDLE next cycle. A new request can be accepted in the IDLE cycle after DONE; no back-to-back accept while busy.
- resp_err is 0 on every non-error response.
- Extension: lb → {{24{b[7]}}, b}, lbu → {24'b0, b}; lh and lhu are analogous with 16-bit lanes. req_signed is ignored for words and stores.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: an access with waddr + 3 >= MEM_BYTES takes the error path (1-cycle resp_err, no memory access).
- Undefined: no range check; waddr is passed to memory unchanged.

Test Plan:
- sw 0x11223344 @0x10, then lw @0x10: mem_write pulse with mem_wr_add = 0x10, resp 2 cycles after accept; lw resp_rdata = 0x11223344, 3 cycles after accept.
- After the first test, sb 0xA5 @0x12: one mem_read, then mem_write with mem_wr_data = 0x11A53344 at mem_wr_add 0x10. Then lb @0x12 → 0xFFFFFFA5 and lbu @0x12 → 0x000000A5.
- Zeroed memory, sh 0x8001 @0x16: mem_wr_add = 0x14, mem_wr_data = 0x80010000. Then lh @0x16 → 0xFFFF8001 and lhu → 0x00008001.
- lw @0x11 and lh @0x13: resp_valid & resp_err the cycle after accept, resp_rdata = 0, mem_read and mem_write stay 0.
- sb @0x20 with rst asserted during CAP: mem_write never asserts, no resp_valid, req_ready = 1 after reset, memory word @0x20 unchanged.
- lw @0x80 with MEM_BYTES = 128:
  - LSU_BOUNDS_CHECK_EN defined → resp_err = 1, no mem_read;
  - LSU_BOUNDS_CHECK_EN undefined → mem_read with mem_rd_add = 0x80.
